// File: rtl/hsv_pkg.sv
// Shared helpers for the RGB->HSV stream converter: width helpers,
// channel expansion and the hue sector bookkeeping.
package hsv_pkg;

   // Hue sector offsets in units of d (R, G, B maximum) and number of sectors.
   localparam int HUE_OFS_R   = 0;
   localparam int HUE_OFS_G   = 2;
   localparam int HUE_OFS_B   = 4;
   localparam int HUE_SECTORS = 6;

   // Which channel won the max comparison (ties go R, then G, then B).
   typedef enum logic [1:0] {
      SEC_R = 2'd0,
      SEC_G = 2'd1,
      SEC_B = 2'd2
   } sector_e;

   // Hue numerator width: holds values up to 6*(2^CW-1).
   function automatic int cw_n_of(input int cw);
      return cw + 3;
   endfunction

   // Hue dividend width: numerator shifted left by the quotient width.
   function automatic int dividend_w_of(input int cw, input int hs_bits);
      return cw + 3 + hs_bits;
   endfunction

   // Widen an in_bits channel to cw bits by cyclic MSB-first bit replication.
   function automatic logic [31:0] chan_expand(input logic [31:0] value, input int in_bits,
                                               input int cw);
      logic [31:0] res;
      res = '0;
      for (int k = 0; k < cw; k++) begin
         res = res | (((value >> (in_bits - 1 - (k % in_bits))) & 32'd1) << (cw - 1 - k));
      end
      return res;
   endfunction

endpackage

// File: rtl/hsv_pipe_div.sv
// Pipelined restoring divider: one quotient bit per stage, QW stages.
// The caller guarantees dividend < divisor * 2^QW and divisor != 0.
// Dividend bits, divisor and a passthrough word travel with the remainder.
module hsv_pipe_div
   import hsv_pkg::*;
#(
   parameter int DW = 17,
   parameter int VW = 9,
   parameter int QW = 8,
   parameter int PW = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic [DW-1:0] dividend,
   input  logic [VW-1:0] divisor,
   input  logic [PW-1:0] pass_in,
   output logic [QW-1:0] quotient,
   output logic [PW-1:0] pass_out
);

   logic [VW-1:0] rem_reg  [QW];
   logic [QW-1:0] dvd_reg  [QW];
   logic [VW-1:0] dvs_reg  [QW];
   logic [QW-1:0] quo_reg  [QW];
   logic [PW-1:0] pass_reg [QW];

   generate
      for (genvar gi = 0; gi < QW; gi++) begin : g_stage
         logic [VW-1:0] rem_prev;
         logic [VW-1:0] dvs_prev;
         logic [VW-1:0] rem_next;
         logic [QW-1:0] dvd_prev;
         logic [QW-1:0] quo_prev;
         logic [QW-1:0] quo_next;
         logic [PW-1:0] pass_prev;
         logic [VW:0]   trial;
         logic [VW:0]   diff;
         logic          ge;

         if (gi == 0) begin : g_first
            // High dividend bits are already below the divisor and seed the remainder.
            assign rem_prev  = VW'(dividend >> QW);
            assign dvd_prev  = dividend[QW-1:0];
            assign dvs_prev  = divisor;
            assign quo_prev  = '0;
            assign pass_prev = pass_in;
         end else begin : g_rest
            assign rem_prev  = rem_reg[gi-1];
            assign dvd_prev  = dvd_reg[gi-1];
            assign dvs_prev  = dvs_reg[gi-1];
            assign quo_prev  = quo_reg[gi-1];
            assign pass_prev = pass_reg[gi-1];
         end

         // Bring down the next dividend bit and try one subtraction.
         assign trial    = {rem_prev, dvd_prev[QW-1]};
         assign diff     = trial - {1'b0, dvs_prev};
         assign ge       = (trial >= {1'b0, dvs_prev});
         assign rem_next = VW'(ge ? diff : trial);
         assign quo_next = quo_prev | (QW'(ge) << (QW - 1 - gi));

         // Stage register; the whole stage freezes while the pipeline is stalled.
         always_ff @(posedge clk) begin
            if (rst) begin
               rem_reg[gi]  <= '0;
               dvd_reg[gi]  <= '0;
               dvs_reg[gi]  <= '0;
               quo_reg[gi]  <= '0;
               pass_reg[gi] <= '0;
            end else if (en) begin
               rem_reg[gi]  <= rem_next;
               dvd_reg[gi]  <= dvd_prev << 1;
               dvs_reg[gi]  <= dvs_prev;
               quo_reg[gi]  <= quo_next;
               pass_reg[gi] <= pass_prev;
            end
         end
      end
   endgenerate

   assign quotient = quo_reg[QW-1];
   assign pass_out = pass_reg[QW-1];

endmodule

// File: rtl/rgb_to_hsv_stream.sv
// Streaming RGB->HSV converter with valid/ready handshake.
// Stage 1 finds max/min/hue numerator, two pipelined dividers produce H and S,
// and a final register assembles the output. One pixel per clock, fixed latency.
module rgb_to_hsv_stream
   import hsv_pkg::*;
#(
   parameter int R_BITS   = 5,
   parameter int G_BITS   = 6,
   parameter int B_BITS   = 5,
   parameter int CW       = 6,
   parameter int HS_BITS  = 8,
   parameter int TAG_BITS = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [R_BITS-1:0]   r,
   input  logic [G_BITS-1:0]   g,
   input  logic [B_BITS-1:0]   b,
   input  logic [TAG_BITS-1:0] in_tag,
   input  logic                in_valid,
   output logic                in_ready,
   output logic [HS_BITS-1:0]  h,
   output logic [HS_BITS-1:0]  s,
   output logic [CW-1:0]       v,
   output logic [TAG_BITS-1:0] out_tag,
   output logic                out_valid,
   input  logic                out_ready
);

   localparam int CW_N       = cw_n_of(CW);
   localparam int DIVIDEND_W = dividend_w_of(CW, HS_BITS);
   localparam int SD_W       = CW + HS_BITS;
   localparam int PW         = CW + TAG_BITS + 2;

   // Whole pipeline advances together; bubbles are kept, not collapsed.
   logic en;
   assign en       = !out_valid || out_ready;
   assign in_ready = en;

   logic [CW-1:0]   r_x, g_x, b_x, mx, mn, d;
   logic [CW_N-1:0] r_n, g_n, b_n, d_n, d6_n, num;
   sector_e         sector;

   // Expand channels, pick the max with R>G>B priority and form the hue numerator.
   always_comb begin
      r_x  = CW'(chan_expand(32'(r), R_BITS, CW));
      g_x  = CW'(chan_expand(32'(g), G_BITS, CW));
      b_x  = CW'(chan_expand(32'(b), B_BITS, CW));
      if (r_x >= g_x && r_x >= b_x) begin
         sector = SEC_R;
         mx     = r_x;
      end else if (g_x >= b_x) begin
         sector = SEC_G;
         mx     = g_x;
      end else begin
         sector = SEC_B;
         mx     = b_x;
      end
      mn = r_x;
      if (g_x < mn) mn = g_x;
      if (b_x < mn) mn = b_x;
      d    = mx - mn;
      r_n  = CW_N'(r_x);
      g_n  = CW_N'(g_x);
      b_n  = CW_N'(b_x);
      d_n  = CW_N'(d);
      d6_n = CW_N'(HUE_SECTORS) * d_n;
      case (sector)
         SEC_R:   num = (g_x >= b_x) ? CW_N'(HUE_OFS_R) * d_n + g_n - b_n
                                     : d6_n - (b_n - g_n);
         SEC_G:   num = CW_N'(HUE_OFS_G) * d_n + b_n - r_n;
         default: num = CW_N'(HUE_OFS_B) * d_n + r_n - g_n;
      endcase
   end

   logic                s1_valid_reg;
   logic                s1_zero_reg;
   logic [TAG_BITS-1:0] s1_tag_reg;
   logic [CW-1:0]       s1_mx_reg;
   logic [CW-1:0]       s1_d_reg;
   logic [CW_N-1:0]     s1_num_reg;
   logic [CW_N-1:0]     s1_d6_reg;

   // Stage-1 register: capture the pixel's max, delta and hue numerator.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_reg <= 1'b0;
         s1_zero_reg  <= 1'b0;
         s1_tag_reg   <= '0;
         s1_mx_reg    <= '0;
         s1_d_reg     <= '0;
         s1_num_reg   <= '0;
         s1_d6_reg    <= '0;
      end else if (en) begin
         s1_valid_reg <= in_valid;
         s1_zero_reg  <= (d == '0);
         s1_tag_reg   <= in_tag;
         s1_mx_reg    <= mx;
         s1_d_reg     <= d;
         s1_num_reg   <= num;
         s1_d6_reg    <= d6_n;
      end
   end

   // Divider operands; zero divisors are replaced by 1 and the result masked later.
   logic [DIVIDEND_W-1:0] h_dividend;
   logic [CW_N-1:0]       h_divisor;
   logic [SD_W-1:0]       s_dividend;
   logic [CW-1:0]         s_divisor;
   logic [PW-1:0]         h_pass_in, h_pass_out;
   logic [HS_BITS-1:0]    h_q, s_q;
   logic                  s_zero;

   assign h_dividend = {s1_num_reg, {HS_BITS{1'b0}}};
   assign h_divisor  = s1_zero_reg ? CW_N'(1) : s1_d6_reg;
   assign s_dividend = {s1_d_reg, {HS_BITS{1'b0}}} - SD_W'(s1_d_reg);
   assign s_divisor  = (s1_mx_reg == '0) ? CW'(1) : s1_mx_reg;
   assign h_pass_in  = {s1_valid_reg, s1_zero_reg, s1_mx_reg, s1_tag_reg};

   hsv_pipe_div #(
      .DW(DIVIDEND_W), .VW(CW_N), .QW(HS_BITS), .PW(PW)
   ) u_div_h (
      .clk(clk), .rst(rst), .en(en),
      .dividend(h_dividend), .divisor(h_divisor), .pass_in(h_pass_in),
      .quotient(h_q), .pass_out(h_pass_out)
   );

   hsv_pipe_div #(
      .DW(SD_W), .VW(CW), .QW(HS_BITS), .PW(1)
   ) u_div_s (
      .clk(clk), .rst(rst), .en(en),
      .dividend(s_dividend), .divisor(s_divisor), .pass_in(s1_zero_reg),
      .quotient(s_q), .pass_out(s_zero)
   );

   logic                p_valid, p_zero;
   logic [CW-1:0]       p_v;
   logic [TAG_BITS-1:0] p_tag;
   assign {p_valid, p_zero, p_v, p_tag} = h_pass_out;

   // Output register: mask grey pixels to zero H/S and present the result.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         h         <= '0;
         s         <= '0;
         v         <= '0;
         out_tag   <= '0;
      end else if (en) begin
         out_valid <= p_valid;
         h         <= p_zero ? '0 : h_q;
         s         <= s_zero ? '0 : s_q;
         v         <= p_v;
         out_tag   <= p_tag;
      end
   end

endmodule

// File: tb/tb_rgb_to_hsv_stream.sv
// Bench for rgb_to_hsv_stream: directed colours with latency, a randomized
// backpressured stream against an arithmetic HSV model, mid-stream reset,
// and an 8-bit / 10-bit-hue parameterisation.
module tb_rgb_to_hsv_stream;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic [4:0] r, b;
   logic [5:0] g;
   logic       in_tag, in_valid, in_ready;
   logic [7:0] h, s;
   logic [5:0] v;
   logic       out_tag, out_valid, out_ready;

   rgb_to_hsv_stream dut (
      .clk(clk), .rst(rst), .r(r), .g(g), .b(b), .in_tag(in_tag),
      .in_valid(in_valid), .in_ready(in_ready), .h(h), .s(s), .v(v),
      .out_tag(out_tag), .out_valid(out_valid), .out_ready(out_ready)
   );

   logic [7:0] r8, g8, b8, v8;
   logic [9:0] h8, s8;
   logic       tag8_in, valid8, ready8, tag8_out, ovalid8, oready8;

   rgb_to_hsv_stream #(
      .R_BITS(8), .G_BITS(8), .B_BITS(8), .CW(8), .HS_BITS(10), .TAG_BITS(1)
   ) dut8 (
      .clk(clk), .rst(rst), .r(r8), .g(g8), .b(b8), .in_tag(tag8_in),
      .in_valid(valid8), .in_ready(ready8), .h(h8), .s(s8), .v(v8),
      .out_tag(tag8_out), .out_valid(ovalid8), .out_ready(oready8)
   );

   int checks = 0;
   int errors = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Reference: replicate bits to cw, hue from sector formulas, plain integer division.
   function automatic int expand(input int val, input int bits, input int cw);
      return (val << (cw - bits)) | (val >> (2 * bits - cw));
   endfunction

   function automatic void ref_hsv(input int rv, input int gv, input int bv,
                                   input int rb, input int gb, input int bb,
                                   input int cw, input int hs,
                                   output int ho, output int so, output int vo);
      int rr, gg, bbv, mx, mn, d, n;
      rr  = expand(rv, rb, cw);
      gg  = expand(gv, gb, cw);
      bbv = expand(bv, bb, cw);
      mx  = rr; if (gg > mx) mx = gg; if (bbv > mx) mx = bbv;
      mn  = rr; if (gg < mn) mn = gg; if (bbv < mn) mn = bbv;
      d   = mx - mn;
      if (rr == mx) begin
         n = gg - bbv;
         if (n < 0) n = n + 6 * d;
      end else if (gg == mx) n = 2 * d + bbv - rr;
      else n = 4 * d + rr - gg;
      ho = (d == 0) ? 0 : (n * (1 << hs)) / (6 * d);
      so = (mx == 0) ? 0 : (d * ((1 << hs) - 1)) / mx;
      vo = mx;
   endfunction

   // Push one pixel into an idle default DUT and wait (bounded) for its result.
   task automatic send_px(input int rv, input int gv, input int bv, input logic tg,
                          output int lat, output int ho, output int so, output int vo,
                          output int tgo);
      @(negedge clk);
      r = 5'(rv); g = 6'(gv); b = 5'(bv); in_tag = tg; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      ho = int'(h); so = int'(s); vo = int'(v); tgo = int'(out_tag);
   endtask

   task automatic send8(input int rv, input int gv, input int bv,
                        output int lat, output int ho, output int so, output int vo);
      @(negedge clk);
      r8 = 8'(rv); g8 = 8'(gv); b8 = 8'(bv); tag8_in = 1'b1; valid8 = 1'b1;
      @(negedge clk);
      valid8 = 1'b0;
      lat = 1;
      while (!ovalid8 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      ho = int'(h8); so = int'(s8); vo = int'(v8);
   endtask

   typedef struct {
      int r, g, b, h, s, v;
   } vec_t;

   vec_t dir_vec [7] = '{
      '{31,  0,  0,   0, 255, 63},
      '{ 0, 63,  0,  85, 255, 63},
      '{ 0,  0, 31, 170, 255, 63},
      '{31, 63, 31,   0,   0, 63},
      '{ 0,  0,  0,   0,   0,  0},
      '{31,  0, 31, 213, 255, 63},
      '{31, 32,  0,  21, 255, 63}
   };

   logic [22:0] exp_q [$];

   initial begin
      int lat, ho, so, vo, tgo, eh, es, ev;
      int sent, rcvd, cyc, stale;
      logic        stall_prev;
      logic [22:0] held_val, exp_w;

      rst = 1'b1; r = '0; g = '0; b = '0; in_tag = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      r8 = '0; g8 = '0; b8 = '0; tag8_in = 1'b0; valid8 = 1'b0; oready8 = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check_val("rst_out_valid", 64'(out_valid), 64'(0));
      check_val("rst_outputs", 64'({h, s, v, out_tag}), 64'(0));
      check_val("rst_in_ready", 64'(in_ready), 64'(1));
      $display("reset released valid=%0d ready=%0d", out_valid, in_ready);

      // Directed colours, each with its latency.
      for (int i = 0; i < 7; i++) begin
         send_px(dir_vec[i].r, dir_vec[i].g, dir_vec[i].b, 1'(i % 2), lat, ho, so, vo, tgo);
         $display("dir %0d rgb=%0d,%0d,%0d h=%0d s=%0d v=%0d tag=%0d lat=%0d",
                  i, dir_vec[i].r, dir_vec[i].g, dir_vec[i].b, ho, so, vo, tgo, lat);
         check_val("dir_latency", 64'(lat), 64'(10));
         check_val("dir_h", 64'(ho), 64'(dir_vec[i].h));
         check_val("dir_s", 64'(so), 64'(dir_vec[i].s));
         check_val("dir_v", 64'(vo), 64'(dir_vec[i].v));
         check_val("dir_tag", 64'(tgo), 64'(i % 2));
      end

      // Random stream with random valid and backpressure.
      sent = 0; rcvd = 0; cyc = 0; stall_prev = 1'b0; held_val = '0;
      while ((sent < 1000 || rcvd < 1000) && cyc < 20000) begin
         @(negedge clk);
         cyc++;
         if (stall_prev) check_val("stall_hold", 64'({h, s, v, out_tag}), 64'(held_val));
         if (sent < 1000 && $urandom_range(1, 0) == 1) begin
            r = 5'($urandom); g = 6'($urandom); b = 5'($urandom); in_tag = 1'($urandom);
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         out_ready = 1'($urandom);
         #1;
         if (in_valid && in_ready) begin
            ref_hsv(int'(r), int'(g), int'(b), 5, 6, 5, 6, 8, eh, es, ev);
            exp_q.push_back({8'(eh), 8'(es), 6'(ev), in_tag});
            sent++;
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check_val("stream_extra", 64'(1), 64'(0));
            end else begin
               exp_w = exp_q.pop_front();
               check_val("stream_px", 64'({h, s, v, out_tag}), 64'(exp_w));
            end
            $display("px %0d h=%0d s=%0d v=%0d tag=%0d", rcvd, h, s, v, out_tag);
            rcvd++;
         end
         stall_prev = out_valid && !out_ready;
         held_val   = {h, s, v, out_tag};
      end
      check_val("stream_count", 64'(rcvd), 64'(1000));
      check_val("stream_queue_empty", 64'(exp_q.size()), 64'(0));
      in_valid = 1'b0; out_ready = 1'b1;

      // Reset with five pixels in flight.
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         r = 5'($urandom); g = 6'($urandom); b = 5'($urandom); in_tag = 1'b1; in_valid = 1'b1;
         @(negedge clk);
      end
      in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      check_val("midrst_out_valid", 64'(out_valid), 64'(0));
      check_val("midrst_outputs", 64'({h, s, v, out_tag}), 64'(0));
      check_val("midrst_in_ready", 64'(in_ready), 64'(1));
      rst = 1'b0;
      stale = 0;
      repeat (30) begin
         @(negedge clk);
         if (out_valid) stale++;
      end
      check_val("midrst_no_stale", 64'(stale), 64'(0));
      $display("mid-stream reset stale=%0d", stale);
      send_px(0, 63, 0, 1'b1, lat, ho, so, vo, tgo);
      $display("post-reset px h=%0d s=%0d v=%0d lat=%0d", ho, so, vo, lat);
      check_val("post_rst_latency", 64'(lat), 64'(10));
      check_val("post_rst_h", 64'(ho), 64'(85));

      // Wider parameterisation.
      send8(255, 0, 0, lat, ho, so, vo);
      $display("p8 rgb=255,0,0 h=%0d s=%0d v=%0d lat=%0d", ho, so, vo, lat);
      check_val("p8_red_latency", 64'(lat), 64'(12));
      check_val("p8_red_h", 64'(ho), 64'(0));
      check_val("p8_red_s", 64'(so), 64'(1023));
      check_val("p8_red_v", 64'(vo), 64'(255));
      send8(0, 255, 0, lat, ho, so, vo);
      $display("p8 rgb=0,255,0 h=%0d s=%0d v=%0d lat=%0d", ho, so, vo, lat);
      check_val("p8_green_latency", 64'(lat), 64'(12));
      check_val("p8_green_h", 64'(ho), 64'(341));
      check_val("p8_green_s", 64'(so), 64'(1023));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
